// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 4;
  localparam int unsigned DATA_W     = 32;
  // Architectural registers R0..R14 live in the register file; R15 is the PC.
  localparam int unsigned REG_COUNT  = 15;
  localparam logic [REG_ADDR_W-1:0] REG_PC = 4'd15;

  // One buffered multi-cycle result. A cleared valid marks a squashed entry
  // that still occupies its FIFO slot until it reaches the head.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     value;
  } wb_entry_t;

  // Which source owns the write port this cycle.
  typedef enum logic [1:0] {
    GntNone,
    GntPipe,
    GntBuf,
    GntBypass
  } grant_e;

  // True when the destination is backed by a register-file entry.
  function automatic logic reg_writable(input logic [REG_ADDR_W-1:0] dest);
    return 32'(dest) < REG_COUNT;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Ordered circular buffer of multi-cycle results with squash-by-destination
// and a per-slot destination/valid view for hazard detection.
module wb_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  push_i,
  input  wb_entry_t                             push_entry_i,
  input  logic                                  pop_i,
  input  logic                                  squash_i,
  input  logic [REG_ADDR_W-1:0]                 squash_dest_i,
  output wb_entry_t                             head_o,
  output logic [$clog2(DEPTH+1)-1:0]            count_o,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]      dest_vec_o,
  output logic [DEPTH-1:0]                      valid_vec_o
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_entry_t       mem_q [DEPTH];
  wb_entry_t       mem_d [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Next-state: squash matching entries, retire the head, append the tail.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && (count_q != CntW'(DEPTH));

    if (squash_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (mem_q[i].valid && (mem_q[i].dest == squash_dest_i)) begin
          mem_d[i].valid = 1'b0;
        end
      end
    end

    // A retired slot is marked invalid so valid always implies occupied.
    if (do_pop) begin
      mem_d[rd_ptr_q].valid = 1'b0;
      rd_ptr_d              = next_ptr(rd_ptr_q);
    end

    // The push target is never the popped slot: pushes only happen below full.
    if (do_push) begin
      mem_d[wr_ptr_q] = push_entry_i;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end

    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Storage, pointers and occupancy, cleared by synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Expose head and per-slot view for the arbiter and hazard compare.
  always_comb begin
    head_o  = mem_q[rd_ptr_q];
    count_o = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      dest_vec_o[i]  = mem_q[i].dest;
      valid_vec_o[i] = mem_q[i].valid;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, multi-cycle
// results are bypassed or buffered, stale buffered results are squashed, and a
// writeback bubble is requested when the buffer starves.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0]     wb_value,
  input  logic                  mc_valid,
  output logic                  mc_ready,
  input  logic [REG_ADDR_W-1:0] mc_dest,
  input  logic [DATA_W-1:0]     mc_value,
  input  logic [REG_ADDR_W-1:0] src1,
  input  logic [REG_ADDR_W-1:0] src2,
  output logic                  hazard,
  output logic                  stall_wb,
  output logic                  writeBackEn,
  output logic [REG_ADDR_W-1:0] Dest_wb,
  output logic [DATA_W-1:0]     Result_WB,
  output logic                  err_r15
);

  localparam int unsigned CntW    = $clog2(DEPTH + 1);
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

  // FIFO interface
  wb_entry_t                        head;
  wb_entry_t                        push_entry;
  logic [CntW-1:0]                  count;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] dest_vec;
  logic [DEPTH-1:0]                 valid_vec;
  logic                             push, pop, handshake;

  // Grant and port selection
  grant_e                grant;
  logic                  sel_en;
  logic [REG_ADDR_W-1:0] sel_dest;
  logic [DATA_W-1:0]     sel_value;

  // Registered outputs
  logic                  wr_en_q, wr_en_d;
  logic [REG_ADDR_W-1:0] dest_q, dest_d;
  logic [DATA_W-1:0]     result_q, result_d;
  logic                  err_q, err_d;
  logic                  stall_q, stall_d;
  logic [StarveW-1:0]    starve_q, starve_d;
  logic [StarveW-1:0]    starve_inc;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i         (clk),
    .rst_i         (rst),
    .push_i        (push),
    .push_entry_i  (push_entry),
    .pop_i         (pop),
    .squash_i      (wb_en),
    .squash_dest_i (wb_dest),
    .head_o        (head),
    .count_o       (count),
    .dest_vec_o    (dest_vec),
    .valid_vec_o   (valid_vec)
  );

  // Ready depends only on registered occupancy, so no path from mc_valid.
  assign mc_ready  = !rst && (count < CntW'(DEPTH));
  assign handshake = mc_valid && mc_ready;

  // Port grant: pipeline, then buffer head, then bypass of a fresh result.
  always_comb begin
    grant = GntNone;
    pop   = 1'b0;
    if (wb_en) begin
      grant = GntPipe;
    end else if (count != '0) begin
      // A squashed head is retired without using the port.
      pop   = 1'b1;
      grant = head.valid ? GntBuf : GntNone;
    end else if (handshake) begin
      grant = GntBypass;
    end
    push = handshake && (grant != GntBypass);
    // A same-cycle pipeline write to the same register makes this result stale.
    push_entry.valid = !(wb_en && (mc_dest == wb_dest));
    push_entry.dest  = mc_dest;
    push_entry.value = mc_value;
  end

  // Select the write data for the granted source.
  always_comb begin
    sel_en    = 1'b0;
    sel_dest  = '0;
    sel_value = '0;
    unique case (grant)
      GntPipe: begin
        sel_en    = 1'b1;
        sel_dest  = wb_dest;
        sel_value = wb_value;
      end
      GntBuf: begin
        sel_en    = 1'b1;
        sel_dest  = head.dest;
        sel_value = head.value;
      end
      GntBypass: begin
        sel_en    = 1'b1;
        sel_dest  = mc_dest;
        sel_value = mc_value;
      end
      default: ;
    endcase
  end

  // R15 filter: a granted write to the PC is dropped and flagged.
  always_comb begin
    wr_en_d  = sel_en && reg_writable(sel_dest);
    err_d    = sel_en && (sel_dest == REG_PC);
    dest_d   = wr_en_d ? sel_dest : dest_q;
    result_d = wr_en_d ? sel_value : result_q;
  end

  // Starvation: count pipeline writes that keep a non-empty buffer off the port.
  always_comb begin
    starve_d   = '0;
    stall_d    = 1'b0;
    starve_inc = starve_q + 1'b1;
    if (wb_en && (count != '0)) begin
      if (starve_inc >= StarveW'(STARVE_LIMIT)) begin
        stall_d = 1'b1;
      end else begin
        starve_d = starve_inc;
      end
    end
  end

  // Output register, stall pulse and starvation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q  <= 1'b0;
      dest_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      stall_q  <= 1'b0;
      starve_q <= '0;
    end else begin
      wr_en_q  <= wr_en_d;
      dest_q   <= dest_d;
      result_q <= result_d;
      err_q    <= err_d;
      stall_q  <= stall_d;
      starve_q <= starve_d;
    end
  end

  // Hazard only covers live buffered results; forwarding covers the rest.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_vec[i] && ((dest_vec[i] == src1) || (dest_vec[i] == src2))) begin
        hazard = 1'b1;
      end
    end
  end

  assign writeBackEn = wr_en_q;
  assign Dest_wb     = dest_q;
  assign Result_WB   = result_q;
  assign err_r15     = err_q;
  assign stall_wb    = stall_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (DEPTH=2, STARVE_LIMIT=4).
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst;
  logic        wb_en;
  logic [3:0]  wb_dest;
  logic [31:0] wb_value;
  logic        mc_valid;
  logic        mc_ready;
  logic [3:0]  mc_dest;
  logic [31:0] mc_value;
  logic [3:0]  src1;
  logic [3:0]  src2;
  logic        hazard;
  logic        stall_wb;
  logic        writeBackEn;
  logic [3:0]  Dest_wb;
  logic [31:0] Result_WB;
  logic        err_r15;

  int n_checks = 0;
  int n_fail   = 0;

  wb_port_arbiter #(
    .DEPTH        (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wb_en       (wb_en),
    .wb_dest     (wb_dest),
    .wb_value    (wb_value),
    .mc_valid    (mc_valid),
    .mc_ready    (mc_ready),
    .mc_dest     (mc_dest),
    .mc_value    (mc_value),
    .src1        (src1),
    .src2        (src2),
    .hazard      (hazard),
    .stall_wb    (stall_wb),
    .writeBackEn (writeBackEn),
    .Dest_wb     (Dest_wb),
    .Result_WB   (Result_WB),
    .err_r15     (err_r15)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; wb_en = 1'b0; wb_dest = '0; wb_value = '0;
    mc_valid = 1'b0; mc_dest = '0; mc_value = '0; src1 = '0; src2 = 4'd14;
    #1;
    chk("ready_in_reset", 32'(mc_ready), 0);
    step();
    step();
    chk("rst_wben", 32'(writeBackEn), 0);
    chk("rst_dest", 32'(Dest_wb), 0);
    chk("rst_result", Result_WB, 0);
    chk("rst_stall", 32'(stall_wb), 0);
    chk("rst_err", 32'(err_r15), 0);
    chk("rst_hazard", 32'(hazard), 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(mc_ready), 1);

    // Pipeline write, 1-cycle latency, one-cycle pulse.
    wb_en = 1'b1; wb_dest = 4'd3; wb_value = 32'h11;
    step();
    chk("pipe_wben", 32'(writeBackEn), 1);
    chk("pipe_dest", 32'(Dest_wb), 3);
    chk("pipe_result", Result_WB, 32'h11);
    wb_en = 1'b0;
    step();
    chk("pipe_pulse_end", 32'(writeBackEn), 0);

    // Starvation: mc result buffered behind 6 pipeline writes.
    wb_en = 1'b1; wb_dest = 4'd1; wb_value = 32'h100;
    mc_valid = 1'b1; mc_dest = 4'd5; mc_value = 32'hAA;
    step();                                   // cycle 0 accepted
    mc_valid = 1'b0; src1 = 4'd5;
    #1;
    chk("buf5_hazard", 32'(hazard), 1);
    chk("c0_pipe_dest", 32'(Dest_wb), 1);
    step();                                   // cycle 1
    chk("c2_stall", 32'(stall_wb), 0);
    step();                                   // cycle 2
    step();                                   // cycle 3
    chk("c4_stall", 32'(stall_wb), 0);
    step();                                   // cycle 4 -> stall visible in cycle 5
    chk("c5_stall", 32'(stall_wb), 1);
    step();                                   // cycle 5, wb_en still high
    chk("c6_stall_clear", 32'(stall_wb), 0);
    chk("c6_hazard", 32'(hazard), 1);
    chk("c6_pipe_dest", 32'(Dest_wb), 1);
    wb_en = 1'b0;
    step();                                   // cycle 6, head gets port
    chk("c7_buf_wben", 32'(writeBackEn), 1);
    chk("c7_buf_dest", 32'(Dest_wb), 5);
    chk("c7_buf_result", Result_WB, 32'hAA);
    chk("c7_hazard_fall", 32'(hazard), 0);
    step();
    chk("c8_idle", 32'(writeBackEn), 0);

    // Fill the buffer with 6 and 7, then drain in order.
    wb_en = 1'b1; wb_dest = 4'd2; wb_value = 32'h22;
    mc_valid = 1'b1; mc_dest = 4'd6; mc_value = 32'h66;
    step();
    mc_dest = 4'd7; mc_value = 32'h77;
    #1;
    chk("fill_ready_mid", 32'(mc_ready), 1);
    step();
    wb_en = 1'b0; mc_valid = 1'b0;
    #1;
    chk("full_ready", 32'(mc_ready), 0);
    step();
    chk("drain6_wben", 32'(writeBackEn), 1);
    chk("drain6_dest", 32'(Dest_wb), 6);
    chk("drain6_result", Result_WB, 32'h66);
    chk("drain_ready_back", 32'(mc_ready), 1);
    step();
    chk("drain7_wben", 32'(writeBackEn), 1);
    chk("drain7_dest", 32'(Dest_wb), 7);
    chk("drain7_result", Result_WB, 32'h77);
    step();
    chk("drain_done", 32'(writeBackEn), 0);

    // Squash: buffered R8=1 superseded by pipeline R8=2.
    wb_en = 1'b1; wb_dest = 4'd2; wb_value = 32'h22;
    mc_valid = 1'b1; mc_dest = 4'd8; mc_value = 32'h1;
    step();
    mc_valid = 1'b0; src1 = 4'd8;
    wb_dest = 4'd8; wb_value = 32'h2;
    #1;
    chk("sq_hazard_before", 32'(hazard), 1);
    step();
    chk("sq_pipe_wben", 32'(writeBackEn), 1);
    chk("sq_pipe_dest", 32'(Dest_wb), 8);
    chk("sq_pipe_result", Result_WB, 32'h2);
    chk("sq_hazard_after", 32'(hazard), 0);
    wb_en = 1'b0;
    step();                                   // stale head discarded
    chk("sq_discard", 32'(writeBackEn), 0);
    step();
    chk("sq_no_stale", 32'(writeBackEn), 0);
    chk("sq_ready", 32'(mc_ready), 1);

    // R15 writes dropped from pipeline and bypass.
    wb_en = 1'b1; wb_dest = 4'd15; wb_value = 32'h5;
    step();
    chk("r15_pipe_wben", 32'(writeBackEn), 0);
    chk("r15_pipe_err", 32'(err_r15), 1);
    wb_en = 1'b0;
    step();
    chk("r15_pipe_err_end", 32'(err_r15), 0);
    mc_valid = 1'b1; mc_dest = 4'd15; mc_value = 32'h9;
    #1;
    chk("r15_mc_ready", 32'(mc_ready), 1);
    step();
    chk("r15_byp_wben", 32'(writeBackEn), 0);
    chk("r15_byp_err", 32'(err_r15), 1);
    mc_valid = 1'b0;
    step();
    chk("r15_byp_err_end", 32'(err_r15), 0);

    // Reset with a full buffer discards everything.
    wb_en = 1'b1; wb_dest = 4'd2; wb_value = 32'h22;
    mc_valid = 1'b1; mc_dest = 4'd10; mc_value = 32'hA;
    step();
    mc_dest = 4'd11; mc_value = 32'hB;
    step();
    wb_en = 1'b0; mc_valid = 1'b0; src1 = 4'd10;
    #1;
    chk("pre_rst_full", 32'(mc_ready), 0);
    chk("pre_rst_hazard", 32'(hazard), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(mc_ready), 0);
    step();
    chk("mrst_wben", 32'(writeBackEn), 0);
    chk("mrst_dest", 32'(Dest_wb), 0);
    chk("mrst_result", Result_WB, 0);
    chk("mrst_hazard", 32'(hazard), 0);
    rst = 1'b0;
    #1;
    chk("mrst_ready", 32'(mc_ready), 1);
    step();
    chk("mrst_no_stale1", 32'(writeBackEn), 0);
    step();
    chk("mrst_no_stale2", 32'(writeBackEn), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
